// File: rtl/alu_complete_ctrl_if.sv
// Completion-report inputs and commit-queue writeback outputs of alu_complete_ctrl.
// The ALU/commit side drives as master; the controller attaches as slave.
interface alu_complete_ctrl_if #(
  parameter int NCOMMIT  = 32,
  parameter int LNCOMMIT = 5,
  parameter int NALU     = 2,
  parameter int NWB      = 2
);
  logic [NALU-1:0]          done_valid;
  logic [NALU*LNCOMMIT-1:0] done_addr;
  logic [NALU-1:0]          done_ready;
  logic [NWB-1:0]           wb_valid;
  logic [NWB*LNCOMMIT-1:0]  wb_addr;
  logic [NCOMMIT-1:0]       complete_mask;

  modport master (
    output done_valid, done_addr,
    input  done_ready, wb_valid, wb_addr, complete_mask
  );

  modport slave (
    input  done_valid, done_addr,
    output done_ready, wb_valid, wb_addr, complete_mask
  );
endinterface

// File: rtl/alu_complete_ctrl.sv
// Buffers ALU completion reports in per-ALU FIFOs and writes back up to NWB
// of them per cycle, oldest relative to the commit head first.
module alu_complete_ctrl #(
  parameter int NCOMMIT  = 32,
  parameter int LNCOMMIT = 5,
  parameter int NALU     = 2,
  parameter int NWB      = 2,
  parameter int DEPTH    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [LNCOMMIT-1:0] commit_start,
  input  logic [NCOMMIT-1:0]  commit_kill,
  alu_complete_ctrl_if.slave  bus,
  output logic                overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = $clog2(NALU + 1);

  logic [LNCOMMIT-1:0]     r_addr [NALU][DEPTH];
  logic [DEPTH-1:0]        r_live [NALU];
  logic [PW-1:0]           r_rd_ptr [NALU];
  logic [PW-1:0]           r_wr_ptr [NALU];
  logic [CW-1:0]           r_count [NALU];
  logic                    r_run;
  logic                    r_overflow;
  logic [NWB-1:0]          r_wb_valid;
  logic [NWB*LNCOMMIT-1:0] r_wb_addr;
  logic [NCOMMIT-1:0]      r_complete_mask;

  logic [NALU-1:0]         w_ready;
  logic [NALU-1:0]         w_push;
  logic [NALU-1:0]         w_pop;
  logic [NALU-1:0]         w_nonempty;
  logic [NALU-1:0]         w_elig;
  logic [NALU-1:0]         w_sel;
  logic [NALU-1:0]         w_surv;
  logic [LNCOMMIT-1:0]     w_push_addr [NALU];
  logic [LNCOMMIT-1:0]     w_head_addr [NALU];
  logic [LNCOMMIT-1:0]     w_age [NALU];
  logic [RW-1:0]           w_rank [NALU];
  logic [RW-1:0]           w_slot [NALU];
  logic [NWB-1:0]          w_wb_valid;
  logic [NWB*LNCOMMIT-1:0] w_wb_addr;
  logic [NCOMMIT-1:0]      w_mask;

  // Readiness comes from registered occupancy only; r_run holds it low until the first cycle out of reset.
  for (genvar gi = 0; gi < NALU; gi++) begin : g_head
    assign w_push_addr[gi] = bus.done_addr[gi*LNCOMMIT +: LNCOMMIT];
    assign w_nonempty[gi]  = (r_count[gi] != '0);
    assign w_ready[gi]     = r_run && (r_count[gi] < CW'(DEPTH));
    assign w_push[gi]      = bus.done_valid[gi] & w_ready[gi];
    assign w_head_addr[gi] = r_addr[gi][r_rd_ptr[gi]];
    assign w_elig[gi]      = w_nonempty[gi] & r_live[gi][r_rd_ptr[gi]];
    assign w_age[gi]       = w_head_addr[gi] - commit_start;
    assign w_pop[gi]       = w_nonempty[gi] & (~r_live[gi][r_rd_ptr[gi]] | w_sel[gi]);
    assign w_surv[gi]      = w_sel[gi] & ~commit_kill[w_head_addr[gi]];
  end

  // Rank each eligible head by (age, ALU index); the NWB best ranks win.
  always_comb begin
    for (int i = 0; i < NALU; i++) begin
      w_rank[i] = '0;
      for (int k = 0; k < NALU; k++) begin
        if (w_elig[k] && ((w_age[k] < w_age[i]) || ((w_age[k] == w_age[i]) && (k < i))))
          w_rank[i] = w_rank[i] + RW'(1);
      end
      w_sel[i] = w_elig[i] && (w_rank[i] < RW'(NWB));
    end
  end

  // Port index of a surviving winner counts only older survivors, so ports stay packed from 0.
  always_comb begin
    for (int i = 0; i < NALU; i++) begin
      w_slot[i] = '0;
      for (int k = 0; k < NALU; k++) begin
        if (w_surv[k] && ((w_age[k] < w_age[i]) || ((w_age[k] == w_age[i]) && (k < i))))
          w_slot[i] = w_slot[i] + RW'(1);
      end
    end
  end

  always_comb begin
    w_wb_valid = '0;
    w_wb_addr  = '0;
    w_mask     = '0;
    for (int i = 0; i < NALU; i++) begin
      if (w_surv[i]) begin
        w_mask[w_head_addr[i]] = 1'b1;
        for (int j = 0; j < NWB; j++) begin
          if (w_slot[i] == RW'(j)) begin
            w_wb_valid[j]                       = 1'b1;
            w_wb_addr[j*LNCOMMIT +: LNCOMMIT]   = w_head_addr[i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NALU; i++) begin
        r_live[i]   <= '0;
        r_rd_ptr[i] <= '0;
        r_wr_ptr[i] <= '0;
        r_count[i]  <= '0;
      end
      r_run           <= 1'b0;
      r_overflow      <= 1'b0;
      r_wb_valid      <= '0;
      r_wb_addr       <= '0;
      r_complete_mask <= '0;
    end else begin
      r_run <= 1'b1;
      if (r_run && |(bus.done_valid & ~w_ready))
        r_overflow <= 1'b1;
      for (int i = 0; i < NALU; i++) begin
        for (int e = 0; e < DEPTH; e++) begin
          if (commit_kill[r_addr[i][e]])
            r_live[i][e] <= 1'b0;
        end
        // A push lands after the kill sweep so the fresh live bit wins for its slot.
        if (w_push[i]) begin
          r_addr[i][r_wr_ptr[i]] <= w_push_addr[i];
          r_live[i][r_wr_ptr[i]] <= ~commit_kill[w_push_addr[i]];
          r_wr_ptr[i]            <= r_wr_ptr[i] + PW'(1);
        end
        if (w_pop[i])
          r_rd_ptr[i] <= r_rd_ptr[i] + PW'(1);
        r_count[i] <= r_count[i] + CW'(w_push[i]) - CW'(w_pop[i]);
      end
      r_wb_valid      <= w_wb_valid;
      r_wb_addr       <= w_wb_addr;
      r_complete_mask <= w_mask;
    end
  end

  assign bus.done_ready    = w_ready;
  assign bus.wb_valid      = r_wb_valid;
  assign bus.wb_addr       = r_wb_addr;
  assign bus.complete_mask = r_complete_mask;
  assign overflow          = r_overflow;
endmodule

// File: tb/tb_alu_complete_ctrl.sv
// Drives identical report streams into an NWB=2 and an NWB=1 controller and
// checks both every cycle against queue-based reference models.
module tb_alu_complete_ctrl;
  localparam int NCOMMIT = 32;
  localparam int LNC     = 5;
  localparam int NALU    = 2;
  localparam int DEPTH   = 2;

  typedef struct packed {
    logic [LNC-1:0] addr;
    logic           live;
  } ent_t;

  logic               clk = 1'b0;
  logic               drv_rst_n;
  logic [LNC-1:0]     drv_start;
  logic [NCOMMIT-1:0] drv_kill;
  logic [NALU-1:0]    drv_valid;
  logic [LNC-1:0]     drv_addr [NALU];
  logic               ovf0;
  logic               ovf1;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  ent_t               mq [2][NALU][$];
  bit                 m_run [2];
  bit                 m_ovf [2];
  logic [1:0]         e_valid [2];
  logic [LNC-1:0]     e_addr [2][2];
  logic [NCOMMIT-1:0] e_mask [2];
  logic [NALU-1:0]    e_ready [2];

  alu_complete_ctrl_if #(.NCOMMIT(NCOMMIT), .LNCOMMIT(LNC), .NALU(NALU), .NWB(2)) bus0 ();
  alu_complete_ctrl_if #(.NCOMMIT(NCOMMIT), .LNCOMMIT(LNC), .NALU(NALU), .NWB(1)) bus1 ();

  assign bus0.done_valid = drv_valid;
  assign bus0.done_addr  = {drv_addr[1], drv_addr[0]};
  assign bus1.done_valid = drv_valid;
  assign bus1.done_addr  = {drv_addr[1], drv_addr[0]};

  alu_complete_ctrl #(.NCOMMIT(NCOMMIT), .LNCOMMIT(LNC), .NALU(NALU), .NWB(2), .DEPTH(DEPTH)) dut0 (
    .clk(clk), .reset(drv_rst_n), .commit_start(drv_start), .commit_kill(drv_kill),
    .bus(bus0), .overflow(ovf0)
  );

  alu_complete_ctrl #(.NCOMMIT(NCOMMIT), .LNCOMMIT(LNC), .NALU(NALU), .NWB(1), .DEPTH(DEPTH)) dut1 (
    .clk(clk), .reset(drv_rst_n), .commit_start(drv_start), .commit_kill(drv_kill),
    .bus(bus1), .overflow(ovf1)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock of the reference behaviour for instance n with nwb writeback ports.
  task automatic model_step(input int n, input int nwb);
    bit   taken [NALU];
    bit   rdy [NALU];
    int   order [$];
    int   port;
    ent_t t;
    if (!drv_rst_n) begin
      for (int a = 0; a < NALU; a++) mq[n][a].delete();
      m_run[n]   = 0;
      m_ovf[n]   = 0;
      e_valid[n] = '0;
      e_addr[n][0] = '0;
      e_addr[n][1] = '0;
      e_mask[n]  = '0;
      e_ready[n] = '0;
      return;
    end
    for (int a = 0; a < NALU; a++) begin
      taken[a] = 0;
      rdy[a]   = m_run[n] && (mq[n][a].size() < DEPTH);
    end
    for (int pick = 0; pick < nwb; pick++) begin
      int best = -1;
      int best_age = 0;
      for (int a = 0; a < NALU; a++) begin
        if (!taken[a] && mq[n][a].size() > 0 && mq[n][a][0].live) begin
          int age = (int'(mq[n][a][0].addr) - int'(drv_start) + NCOMMIT) % NCOMMIT;
          if (best < 0 || age < best_age) begin
            best = a;
            best_age = age;
          end
        end
      end
      if (best >= 0) begin
        taken[best] = 1;
        order.push_back(best);
      end
    end
    e_valid[n] = '0;
    e_mask[n]  = '0;
    port = 0;
    foreach (order[k]) begin
      logic [LNC-1:0] h = mq[n][order[k]][0].addr;
      if (!drv_kill[h]) begin
        e_valid[n][port] = 1'b1;
        e_addr[n][port]  = h;
        e_mask[n][h]     = 1'b1;
        port++;
      end
    end
    for (int a = 0; a < NALU; a++) begin
      if (mq[n][a].size() > 0 && (taken[a] || !mq[n][a][0].live))
        void'(mq[n][a].pop_front());
      for (int k = 0; k < mq[n][a].size(); k++) begin
        t = mq[n][a][k];
        if (drv_kill[t.addr]) t.live = 1'b0;
        mq[n][a][k] = t;
      end
      if (drv_valid[a]) begin
        if (rdy[a]) begin
          t.addr = drv_addr[a];
          t.live = !drv_kill[drv_addr[a]];
          mq[n][a].push_back(t);
        end else if (m_run[n]) begin
          m_ovf[n] = 1;
        end
      end
    end
    m_run[n] = 1;
    for (int a = 0; a < NALU; a++)
      e_ready[n][a] = mq[n][a].size() < DEPTH;
  endtask

  task automatic compare_inst(input int n, input logic [1:0] v, input logic [9:0] a,
                              input logic [NCOMMIT-1:0] m, input logic [1:0] r, input logic o);
    check_val($sformatf("i%0d wb_valid", n), 64'(v), 64'(e_valid[n]));
    check_val($sformatf("i%0d complete_mask", n), 64'(m), 64'(e_mask[n]));
    check_val($sformatf("i%0d done_ready", n), 64'(r), 64'(e_ready[n]));
    check_val($sformatf("i%0d overflow", n), 64'(o), 64'(m_ovf[n]));
    for (int j = 0; j < 2; j++)
      if (e_valid[n][j])
        check_val($sformatf("i%0d wb_addr%0d", n, j), 64'(a[j*LNC +: LNC]), 64'(e_addr[n][j]));
  endtask

  task automatic step();
    model_step(0, 2);
    model_step(1, 1);
    @(posedge clk);
    #1;
    cyc++;
    compare_inst(0, bus0.wb_valid, bus0.wb_addr, bus0.complete_mask, bus0.done_ready, ovf0);
    compare_inst(1, {1'b0, bus1.wb_valid}, {5'd0, bus1.wb_addr}, bus1.complete_mask,
                 bus1.done_ready, ovf1);
    if (bus0.wb_valid != '0 || bus1.wb_valid != '0)
      $display("[TB] cyc %0d start=%0d i0 v=%b a=%h mask=%h | i1 v=%b a=%0d", cyc, drv_start,
               bus0.wb_valid, bus0.wb_addr, bus0.complete_mask, bus1.wb_valid, bus1.wb_addr);
  endtask

  task automatic idle(input int n);
    drv_valid = '0;
    drv_kill  = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    drv_rst_n   = 1'b0;
    drv_start   = '0;
    drv_kill    = '0;
    drv_valid   = 2'b11;
    drv_addr[0] = 5'd7;
    drv_addr[1] = 5'd8;

    // Reset held with reports offered: nothing accepted, everything low.
    for (int i = 0; i < 3; i++) step();
    check_val("reset wb_valid", 64'(bus0.wb_valid), 64'd0);
    check_val("reset done_ready", 64'(bus0.done_ready), 64'd0);
    drv_rst_n = 1'b1;
    drv_valid = '0;
    step();
    check_val("post-reset done_ready", 64'(bus0.done_ready), 64'h3);
    check_val("post-reset overflow", 64'(ovf0), 64'd0);

    // Two reports, start=2: oldest (3) on port 0.
    drv_start   = 5'd2;
    drv_valid   = 2'b11;
    drv_addr[0] = 5'd5;
    drv_addr[1] = 5'd3;
    step();
    idle(1);
    check_val("age order wb_valid", 64'(bus0.wb_valid), 64'h3);
    check_val("age order port0", 64'(bus0.wb_addr[4:0]), 64'd3);
    check_val("age order port1", 64'(bus0.wb_addr[9:5]), 64'd5);
    check_val("age order mask", 64'(bus0.complete_mask), 64'h28);
    idle(3);

    // Wrap-around age with a single port.
    drv_start   = 5'd30;
    drv_valid   = 2'b11;
    drv_addr[0] = 5'd1;
    drv_addr[1] = 5'd31;
    step();
    idle(1);
    check_val("wrap first addr", 64'(bus1.wb_addr), 64'd31);
    check_val("wrap first mask", 64'(bus1.complete_mask), 64'h8000_0000);
    idle(1);
    check_val("wrap second addr", 64'(bus1.wb_addr), 64'd1);
    check_val("wrap second mask", 64'(bus1.complete_mask), 64'h2);
    idle(3);

    // Kill of a queued head behind older ALU1 traffic (single-port instance).
    drv_start   = 5'd0;
    drv_valid   = 2'b10;
    drv_addr[1] = 5'd1;
    step();
    drv_valid   = 2'b11;
    drv_addr[0] = 5'd4;
    drv_addr[1] = 5'd2;
    step();
    drv_valid   = 2'b01;
    drv_addr[0] = 5'd6;
    step();
    check_val("kill full ready0", 64'(bus1.done_ready[0]), 64'd0);
    drv_valid   = '0;
    drv_kill    = 32'h1 << 4;
    step();
    check_val("kill silent wb_valid", 64'(bus1.wb_valid), 64'd0);
    check_val("kill ready0 back", 64'(bus1.done_ready[0]), 64'd1);
    idle(1);
    check_val("kill survivor valid", 64'(bus1.wb_valid), 64'd1);
    check_val("kill survivor addr", 64'(bus1.wb_addr), 64'd6);
    idle(3);

    // Overflow: ALU1 starved behind older ALU0 reports on the single-port instance.
    drv_rst_n = 1'b0;
    step();
    drv_rst_n = 1'b1;
    step();
    drv_valid   = 2'b11;
    drv_addr[0] = 5'd1;
    drv_addr[1] = 5'd20;
    for (int i = 0; i < 6; i++) step();
    check_val("overflow set i1", 64'(ovf1), 64'd1);
    check_val("overflow clear i0", 64'(ovf0), 64'd0);
    idle(4);
    check_val("overflow sticky", 64'(ovf1), 64'd1);
    drv_rst_n = 1'b0;
    step();
    drv_rst_n = 1'b1;
    step();

    // Report killed in its push cycle never writes back.
    drv_valid   = 2'b01;
    drv_addr[0] = 5'd9;
    drv_kill    = 32'h1 << 9;
    step();
    idle(1);
    check_val("push-kill no wb", 64'(bus0.wb_valid), 64'd0);
    idle(1);
    check_val("push-kill drained", 64'(bus0.done_ready), 64'h3);

    // Randomized traffic with moving head, sparse kills and occasional reset.
    for (int i = 0; i < 800; i++) begin
      drv_rst_n   = ($urandom_range(0, 149) != 0);
      drv_valid   = 2'($urandom_range(0, 3));
      drv_addr[0] = 5'($urandom_range(0, 31));
      drv_addr[1] = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) drv_start = 5'($urandom_range(0, 31));
      drv_kill = ($urandom_range(0, 4) == 0) ? (32'h1 << $urandom_range(0, 31)) : '0;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
